// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control path.
// State encoding, opcodes and datapath select codes used by the controller and ALU decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } ctrl_state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_DATA   = 2'b01;
  localparam logic [1:0] RESULT_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter: increments on each retire pulse, wraps modulo 2^WIDTH.
module instret_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute over the
// shared datapath, drives mux selects and write enables, counts retirements, traps on bad opcodes.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  ctrl_state_t state_q, state_d;

  logic pc_update, branch;
  logic ir_write_s, reg_write_s, mem_write_s, retire_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_R:         state_d = StExecuteR;
          OP_I:         state_d = StExecuteI;
          OP_BEQ:       state_d = StBeq;
          OP_JAL:       state_d = StJal;
          default:      state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (opcode == OP_SW) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StMemWb:    state_d = StFetch;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
  end

  always_comb begin
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    result_src  = RESULT_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    retire_s    = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      StFetch: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RESULT_ALURES;
        ir_write_s = mem_ready;
        pc_update  = mem_ready;
      end
      // Speculatively compute the branch target into ALUOut.
      StDecode: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      StMemAdr: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      StMemRead: adr_src = 1'b1;
      StMemWrite: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = mem_ready;
      end
      StMemWb: begin
        result_src  = RESULT_DATA;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      StExecuteI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      StAluWb: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      StBeq: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        retire_s  = 1'b1;
      end
      StJal: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      StTrap:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // State already resets to FETCH, whose enables follow mem_ready; mask them during reset.
  assign ir_write  = ir_write_s & ~reset;
  assign pc_write  = (pc_update | (branch & zero)) & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign mem_write = mem_write_s & ~reset;
  assign retire    = retire_s & ~reset;

  instret_counter #(
    .WIDTH(INSTRET_W)
  ) u_instret_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: random instruction mix with random memory stalls,
// checked per instruction against cycle/enable/retire expectations derived from the instruction class.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        adr_src, ir_write, pc_write, reg_write, mem_write, retire, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [31:0] instret;

  logic        adr_src4, ir_write4, pc_write4, reg_write4, mem_write4, retire4, illegal4;
  logic [1:0]  result_src4, alu_src_a4, alu_src_b4, alu_op4;
  logic [3:0]  instret4;

  int          total = 0;
  int          bad   = 0;
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_write(mem_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire), .instret(instret),
    .illegal(illegal)
  );

  multicycle_controller #(.INSTRET_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .adr_src(adr_src4), .ir_write(ir_write4), .pc_write(pc_write4), .reg_write(reg_write4),
    .mem_write(mem_write4), .result_src(result_src4), .alu_src_a(alu_src_a4),
    .alu_src_b(alu_src_b4), .alu_op(alu_op4), .retire(retire4), .instret(instret4),
    .illegal(illegal4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string op_name(input logic [6:0] op);
    case (op)
      OP_LW:   return "lw";
      OP_SW:   return "sw";
      OP_R:    return "rtype";
      OP_I:    return "itype";
      OP_BEQ:  return "beq";
      OP_JAL:  return "jal";
      default: return "other";
    endcase
  endfunction

  // Runs one instruction starting in FETCH. kf = fetch stall cycles, km = data-access stall
  // cycles (lw/sw only), zmode 0/1 forces zero, 2 randomizes it every cycle.
  task automatic run_instr(input logic [6:0] op, input int kf, input int km, input int zmode);
    bit    is_mem, wr_reg;
    int    base, ncyc, kmem;
    int    n_ir = 0, n_pcw = 0, n_rw = 0, n_mw = 0, n_ret = 0, n_ret4 = 0, n_ill = 0;
    logic  ret_last = 1'b0, z_last = 1'b0;
    logic [1:0] rs_last = 2'b00, aop_last = 2'b00;
    int    exp_pcw;
    string nm;
    nm     = op_name(op);
    is_mem = (op == OP_LW) || (op == OP_SW);
    wr_reg = !((op == OP_SW) || (op == OP_BEQ));
    kmem   = is_mem ? km : 0;
    base   = (op == OP_LW) ? 5 : (op == OP_BEQ) ? 3 : 4;
    ncyc   = base + kf + kmem;
    for (int c = 0; c < ncyc; c++) begin
      opcode = op;
      zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      if (c < kf)                                        mem_ready = 1'b0;
      else if (c == kf)                                  mem_ready = 1'b1;
      else if (is_mem && c >= kf + 3 && c < kf + 3 + kmem) mem_ready = 1'b0;
      else if (is_mem && c == kf + 3 + kmem)             mem_ready = 1'b1;
      else                                               mem_ready = 1'($urandom);
      @(negedge clk);
      n_ir   += int'(ir_write);
      n_pcw  += int'(pc_write);
      n_rw   += int'(reg_write);
      n_mw   += int'(mem_write);
      n_ret  += int'(retire);
      n_ret4 += int'(retire4);
      n_ill  += int'(illegal);
      if (c == ncyc - 1) begin
        ret_last = retire;
        z_last   = zero;
        rs_last  = result_src;
        aop_last = alu_op;
      end
      @(posedge clk);
      #1;
    end
    model_cnt++;
    exp_pcw = 1 + ((op == OP_JAL) ? 1 : 0) + ((op == OP_BEQ && z_last) ? 1 : 0);
    chk({nm, ".retire_count"}, n_ret, 1);
    chk({nm, ".retire_last"}, ret_last, 1);
    chk({nm, ".ir_write_count"}, n_ir, 1);
    chk({nm, ".pc_write_count"}, n_pcw, exp_pcw);
    chk({nm, ".reg_write_count"}, n_rw, wr_reg ? 1 : 0);
    chk({nm, ".mem_write_count"}, n_mw, (op == OP_SW) ? kmem + 1 : 0);
    chk({nm, ".illegal_count"}, n_ill, 0);
    chk({nm, ".result_src_last"}, rs_last, (op == OP_LW) ? 2'b01 : 2'b00);
    chk({nm, ".alu_op_last"}, aop_last, (op == OP_BEQ) ? 2'b01 : 2'b00);
    chk({nm, ".instret"}, instret, model_cnt);
    chk({nm, ".instret4"}, {28'd0, instret4}, model_cnt % 16);
    chk({nm, ".retire4_count"}, n_ret4, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] ops [6];
    int unsigned start_cnt;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;

    // Reset with mem_ready high: FETCH would otherwise assert ir_write/pc_write.
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_R; zero = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.ir_write", ir_write, 0);
    chk("rst.pc_write", pc_write, 0);
    chk("rst.reg_write", reg_write, 0);
    chk("rst.mem_write", mem_write, 0);
    chk("rst.retire", retire, 0);
    chk("rst.instret", instret, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst.fetch_ir_write", ir_write, 1);
    chk("rst.fetch_alu_src_b", alu_src_b, SRCB_FOUR);
    chk("rst.fetch_result_src", result_src, RESULT_ALURES);

    run_instr(OP_LW, 0, 0, 2);
    run_instr(OP_SW, 0, 2, 2);
    run_instr(OP_BEQ, 0, 0, 1);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(OP_JAL, 1, 0, 2);

    for (int i = 0; i < 40; i++) begin
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3), 2);
    end

    start_cnt = model_cnt;
    for (int i = 0; i < 16; i++) run_instr(OP_R, 0, 0, 2);
    chk("wrap16.instret4", {28'd0, instret4}, start_cnt % 16);

    // Abandon a lw in MEMREAD with mem_ready high: no write-back, not counted.
    opcode = OP_LW; mem_ready = 1'b1; zero = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    model_cnt = 0;
    chk("midrst.reg_write", reg_write, 0);
    chk("midrst.retire", retire, 0);
    chk("midrst.ir_write", ir_write, 0);
    chk("midrst.instret", instret, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst.fetch_ir_write", ir_write, 1);
    run_instr(OP_R, 0, 0, 2);

    // Illegal opcode: FETCH, DECODE, then stuck in TRAP.
    opcode = 7'b1111111; mem_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("trap.decode_illegal", illegal, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'($urandom);
      zero      = 1'($urandom);
      @(negedge clk);
      chk("trap.illegal", illegal, 1);
      chk("trap.enables", {27'd0, ir_write, pc_write, reg_write, mem_write, retire}, 0);
      @(posedge clk); #1;
    end
    chk("trap.instret", instret, model_cnt);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("trap.reset_illegal", illegal, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt = 0;
    #1;
    chk("trap.reset_fetch", ir_write, 1);
    run_instr(OP_JAL, 0, 0, 2);
    run_instr(OP_LW, 2, 3, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
